commit_branch_tracker: RTL and testbench

COMMIT_BRANCH_TRACKER -- requirements
Module: commit_branch_tracker

---
 rtl/branch_defs.sv | 29 ++
 rtl/commit_branch_entry.sv | 52 +++++
 rtl/commit_branch_tracker.sv | 146 ++++++++++++++
 tb/tb_commit_branch_tracker.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/branch_defs.sv
// Shared core branch definitions: ID width, tracker depth, FSM encodings and
// the per-entry record used by the commit branch tracker.
package branch_defs;

    localparam int BID_W = 4;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
    localparam int CNT_W = 3;

    localparam logic [CNT_W-1:0] CNT_FULL = 3'd4;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } trk_state_e;

    typedef struct packed {
        logic             valid;
        logic [BID_W-1:0] bid;
        logic             resolved;
        logic             mispredict;
    } entry_t;

    // Circular pointer advance; the natural 2-bit wrap gives modulo-4.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/commit_branch_entry.sv
// One tracker slot: holds a branch record and resolves it when execute
// reports a matching branch ID.
module commit_branch_entry
    import branch_defs::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             deq,
    input  logic             alloc_we,
    input  logic [BID_W-1:0] alloc_bid,
    input  logic             res_valid,
    input  logic [BID_W-1:0] res_bid,
    input  logic             res_mispredict,
    output entry_t           entry
);

    entry_t entry_d;
    entry_t entry_q;
    logic   hit_s;

    // Next slot contents: flush/dequeue beat allocation, which beats resolution.
    always_comb begin
        entry_d = entry_q;
        hit_s   = res_valid && entry_q.valid && (entry_q.bid == res_bid);
        if (clear || deq) begin
            entry_d = '0;
        end else if (alloc_we) begin
            entry_d.valid      = 1'b1;
            entry_d.bid        = alloc_bid;
            entry_d.resolved   = 1'b0;
            entry_d.mispredict = 1'b0;
        end else if (hit_s) begin
            entry_d.resolved   = 1'b1;
            entry_d.mispredict = res_mispredict;
        end else begin
            entry_d = entry_q;
        end
    end

    // Slot storage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry = entry_q;

endmodule

// File: rtl/commit_branch_tracker.sv
// In-order tracker of predicted branches between decode and commit. Emits a
// commit pulse per retired branch and an override pulse plus a one-cycle
// recovery window when a mispredicted branch retires.
module commit_branch_tracker
    import branch_defs::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             snoop_hit,
    input  logic             en_alloc,
    input  logic             bp_valid,
    input  logic [BID_W-1:0] bp_bid,
    input  logic             ex_valid,
    input  logic [BID_W-1:0] ex_bid,
    input  logic             ex_mispredict,
    input  logic             commit_ready,
    output logic             bc_valid,
    output logic [BID_W-1:0] bc_bid,
    output logic             bco_valid,
    output logic             alloc_readyn,
    output logic [CNT_W-1:0] count
);

    trk_state_e       state_q, state_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             bc_valid_q, bc_valid_d;
    logic             bco_valid_q, bco_valid_d;
    logic [BID_W-1:0] bc_bid_q, bc_bid_d;
    logic             alloc_readyn_q, alloc_readyn_d;

    entry_t           ent_s [DEPTH];
    entry_t           head_ent_s;
    logic [DEPTH-1:0] alloc_we_s;
    logic [DEPTH-1:0] deq_s;
    logic             clear_s;
    logic             res_valid_s;
    logic             run_s;
    logic             alloc_ok_s;
    logic             commit_s;

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        commit_branch_entry u_entry (
            .clk            (clk),
            .reset          (reset),
            .clear          (clear_s),
            .deq            (deq_s[g]),
            .alloc_we       (alloc_we_s[g]),
            .alloc_bid      (bp_bid),
            .res_valid      (res_valid_s),
            .res_bid        (ex_bid),
            .res_mispredict (ex_mispredict),
            .entry          (ent_s[g])
        );
    end

    // Next-state/output logic: snoop flush > mispredict commit > recovery > normal.
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        bc_valid_d  = 1'b0;
        bco_valid_d = 1'b0;
        bc_bid_d    = bc_bid_q;
        clear_s     = 1'b0;
        res_valid_s = 1'b0;
        alloc_we_s  = '0;
        deq_s       = '0;

        head_ent_s = ent_s[head_q];
        run_s      = (state_q == ST_RUN);
        // The full flag comes from the register, so a commit in the same
        // cycle cannot free a slot for an allocation.
        alloc_ok_s = run_s && en_alloc && bp_valid && !alloc_readyn_q;
        commit_s   = run_s && head_ent_s.valid && head_ent_s.resolved && commit_ready;

        if (snoop_hit) begin
            clear_s = 1'b1;
            head_d  = 2'd0;
            tail_d  = 2'd0;
            count_d = 3'd0;
            state_d = ST_RUN;
        end else if (commit_s && head_ent_s.mispredict) begin
            bc_valid_d  = 1'b1;
            bco_valid_d = 1'b1;
            bc_bid_d    = head_ent_s.bid;
            clear_s     = 1'b1;
            head_d      = 2'd0;
            tail_d      = 2'd0;
            count_d     = 3'd0;
            state_d     = ST_RECOVER;
        end else if (!run_s) begin
            state_d = ST_RUN;
        end else begin
            res_valid_s = ex_valid;
            if (commit_s) begin
                bc_valid_d    = 1'b1;
                bc_bid_d      = head_ent_s.bid;
                deq_s[head_q] = 1'b1;
                head_d        = ptr_inc(head_q);
            end else begin
                head_d = head_q;
            end
            if (alloc_ok_s) begin
                alloc_we_s[tail_q] = 1'b1;
                tail_d             = ptr_inc(tail_q);
            end else begin
                tail_d = tail_q;
            end
            count_d = count_q + {2'b00, alloc_ok_s} - {2'b00, commit_s};
        end

        alloc_readyn_d = (count_d == CNT_FULL) || (state_d == ST_RECOVER);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            head_q         <= 2'd0;
            tail_q         <= 2'd0;
            count_q        <= 3'd0;
            bc_valid_q     <= 1'b0;
            bco_valid_q    <= 1'b0;
            bc_bid_q       <= 4'd0;
            alloc_readyn_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            bc_valid_q     <= bc_valid_d;
            bco_valid_q    <= bco_valid_d;
            bc_bid_q       <= bc_bid_d;
            alloc_readyn_q <= alloc_readyn_d;
        end
    end

    assign bc_valid     = bc_valid_q;
    assign bco_valid    = bco_valid_q;
    assign bc_bid       = bc_bid_q;
    assign alloc_readyn = alloc_readyn_q;
    assign count        = count_q;

endmodule

// File: tb/tb_commit_branch_tracker.sv
// Directed bench for commit_branch_tracker with a scoreboard of expected
// commit pulses.
module tb_commit_branch_tracker;

    logic       clk = 1'b0;
    logic       reset, snoop_hit, en_alloc, bp_valid, ex_valid, ex_mispredict, commit_ready;
    logic [3:0] bp_bid, ex_bid;
    logic       bc_valid, bco_valid, alloc_readyn;
    logic [3:0] bc_bid;
    logic [2:0] count;

    typedef struct {
        logic [3:0] bid;
        logic       bco;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    commit_branch_tracker dut (
        .clk           (clk),
        .reset         (reset),
        .snoop_hit     (snoop_hit),
        .en_alloc      (en_alloc),
        .bp_valid      (bp_valid),
        .bp_bid        (bp_bid),
        .ex_valid      (ex_valid),
        .ex_bid        (ex_bid),
        .ex_mispredict (ex_mispredict),
        .commit_ready  (commit_ready),
        .bc_valid      (bc_valid),
        .bc_bid        (bc_bid),
        .bco_valid     (bco_valid),
        .alloc_readyn  (alloc_readyn),
        .count         (count)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [3:0] bid, input logic bco);
        exp_t e;
        e.bid = bid;
        e.bco = bco;
        exp_q.push_back(e);
    endtask

    // One clock; sample 1ns after the edge and score any commit pulse.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (bc_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("bc_unexpected", 8'd1, 8'd0);
            end else begin
                e = exp_q.pop_front();
                chk("bc_bid", {4'd0, bc_bid}, {4'd0, e.bid});
                chk("bco_valid", {7'd0, bco_valid}, {7'd0, e.bco});
            end
        end else begin
            chk("bc_idle", {6'd0, bc_valid, bco_valid}, 8'd0);
        end
    endtask

    task automatic idle();
        en_alloc = 1'b0; bp_valid = 1'b0; bp_bid = 4'd0;
        ex_valid = 1'b0; ex_bid = 4'd0; ex_mispredict = 1'b0;
        commit_ready = 1'b0; snoop_hit = 1'b0;
    endtask

    task automatic alloc(input logic [3:0] bid);
        idle();
        en_alloc = 1'b1; bp_valid = 1'b1; bp_bid = bid;
        tick();
    endtask

    task automatic resolve(input logic [3:0] bid, input logic mis);
        idle();
        ex_valid = 1'b1; ex_bid = bid; ex_mispredict = mis;
        tick();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_count", {5'd0, count}, 8'd0);
        chk("rst_readyn", {7'd0, alloc_readyn}, 8'd0);
        chk("rst_bc_bid", {4'd0, bc_bid}, 8'd0);
        reset = 1'b0;
        tick();

        // Two branches resolved out of order retire in order.
        alloc(4'd1);
        alloc(4'd2);
        chk("s1_count2", {5'd0, count}, 8'd2);
        resolve(4'd2, 1'b0);
        resolve(4'd1, 1'b0);
        idle();
        commit_ready = 1'b1;
        push(4'd1, 1'b0);
        push(4'd2, 1'b0);
        tick();
        chk("s1_count1", {5'd0, count}, 8'd1);
        tick();
        chk("s1_count0", {5'd0, count}, 8'd0);
        chk("s1_sb_empty", 8'(exp_q.size()), 8'd0);

        // Fill to four, overflow allocation ignored, commit frees a slot.
        alloc(4'd4);
        alloc(4'd5);
        alloc(4'd6);
        alloc(4'd7);
        chk("s2_readyn_full", {7'd0, alloc_readyn}, 8'd1);
        chk("s2_count4", {5'd0, count}, 8'd4);
        alloc(4'd8);
        chk("s2_count_held", {5'd0, count}, 8'd4);
        resolve(4'd4, 1'b0);
        idle();
        commit_ready = 1'b1;
        push(4'd4, 1'b0);
        tick();
        chk("s2_readyn_free", {7'd0, alloc_readyn}, 8'd0);
        chk("s2_count3", {5'd0, count}, 8'd3);

        // Commit and allocate together below full: count unchanged.
        resolve(4'd5, 1'b0);
        idle();
        commit_ready = 1'b1;
        en_alloc = 1'b1; bp_valid = 1'b1; bp_bid = 4'd8;
        push(4'd5, 1'b0);
        tick();
        chk("s3_count_same", {5'd0, count}, 8'd3);

        // Commit and allocate together at full: allocation rejected.
        alloc(4'd9);
        chk("s3_full", {5'd0, count}, 8'd4);
        resolve(4'd6, 1'b0);
        idle();
        commit_ready = 1'b1;
        en_alloc = 1'b1; bp_valid = 1'b1; bp_bid = 4'd10;
        push(4'd6, 1'b0);
        tick();
        chk("s3_full_commit", {5'd0, count}, 8'd3);

        // Snoop flush with a resolved head and commit_ready: no pulse.
        resolve(4'd7, 1'b0);
        idle();
        snoop_hit = 1'b1;
        commit_ready = 1'b1;
        tick();
        chk("s4_snoop_count", {5'd0, count}, 8'd0);
        chk("s4_sb_empty", 8'(exp_q.size()), 8'd0);

        // Untracked resolve and same-cycle resolve have no effect.
        alloc(4'd1);
        idle();
        ex_valid = 1'b1; ex_bid = 4'd9;
        commit_ready = 1'b1;
        tick();
        idle();
        commit_ready = 1'b1;
        tick();
        chk("s5_count1", {5'd0, count}, 8'd1);
        idle();
        en_alloc = 1'b1; bp_valid = 1'b1; bp_bid = 4'd2;
        ex_valid = 1'b1; ex_bid = 4'd2;
        tick();
        resolve(4'd1, 1'b0);
        idle();
        commit_ready = 1'b1;
        push(4'd1, 1'b0);
        tick();
        tick();
        tick();
        chk("s5_unresolved_held", {5'd0, count}, 8'd1);
        idle();
        snoop_hit = 1'b1;
        tick();

        // Mispredict commit: override pulse, flush, one recovery cycle.
        alloc(4'd3);
        alloc(4'd4);
        resolve(4'd3, 1'b1);
        idle();
        commit_ready = 1'b1;
        push(4'd3, 1'b1);
        tick();
        chk("s6_count0", {5'd0, count}, 8'd0);
        chk("s6_readyn_rec", {7'd0, alloc_readyn}, 8'd1);
        alloc(4'd5);
        chk("s6_readyn_run", {7'd0, alloc_readyn}, 8'd0);
        chk("s6_alloc_dropped", {5'd0, count}, 8'd0);
        chk("s6_sb_empty", 8'(exp_q.size()), 8'd0);

        // Reset during a pending commit: no pulse, reset values.
        alloc(4'd1);
        resolve(4'd1, 1'b0);
        idle();
        commit_ready = 1'b1;
        reset = 1'b1;
        tick();
        chk("s7_count", {5'd0, count}, 8'd0);
        chk("s7_readyn", {7'd0, alloc_readyn}, 8'd0);
        chk("s7_bc_bid", {4'd0, bc_bid}, 8'd0);
        reset = 1'b0;
        idle();
        commit_ready = 1'b1;
        tick();
        chk("s7_after_count", {5'd0, count}, 8'd0);

        chk("sb_drain", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
